// File: rtl/pending_req_pkg.sv
// Shared constants and helpers for the pending-request arbiter.
// Holds the default channel count, dropped-counter width and index-width helper.
package pending_req_pkg;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_DROP_W = 8;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pending_req_arbiter_rr_pick.sv
// Combinational round-robin search: returns the first set bit at or above ptr,
// wrapping from NUM_CH-1 back to 0. idx reads 0 when nothing is set.
module rr_pick
  import pending_req_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_vec,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] ch_idx;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    ch_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      ch_idx = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (req_vec[ch_idx]) begin
        valid = 1'b1;
        idx   = ch_idx;
      end
    end
  end

endmodule

// File: rtl/pending_req_arbiter.sv
// Per-channel pending-request latch with a round-robin grant handshake and a
// saturating count of requests that land on an already-pending channel.
module pending_req_arbiter
  import pending_req_pkg::*;
#(
  parameter int NUM_CH       = DEFAULT_NUM_CH,
  parameter int DROP_W       = DEFAULT_DROP_W,
  parameter int CLR_ON_GRANT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         clr,
  input  logic                      grant_ready,
  output logic [NUM_CH-1:0]         pending,
  output logic                      grant_valid,
  output logic [idx_w(NUM_CH)-1:0]  grant_idx,
  output logic [DROP_W-1:0]         dropped
);

  localparam int IDX_W = idx_w(NUM_CH);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v,
                                                 input logic              en);
    if (en && (v != '1)) return v + DROP_W'(1);
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(NUM_CH - 1)) return '0;
    return v + IDX_W'(1);
  endfunction

  logic [NUM_CH-1:0] pending_p1;
  logic [IDX_W-1:0]  rr_ptr_p1;
  logic [DROP_W-1:0] dropped_p1;

  logic [NUM_CH-1:0] pending_p0;
  logic [IDX_W-1:0]  rr_ptr_p0;
  logic [DROP_W-1:0] dropped_p0;
  logic [NUM_CH-1:0] accept_vec;
  logic              accept;
  logic              drop_hit;

  // Grant side: depends only on registered pending and the pointer.
  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req_vec (pending_p1),
    .ptr     (rr_ptr_p1),
    .valid   (grant_valid),
    .idx     (grant_idx)
  );

  assign accept = grant_valid & grant_ready;

  always_comb begin
    accept_vec = '0;
    pending_p0 = pending_p1;
    for (int i = 0; i < NUM_CH; i++) begin
      accept_vec[i] = accept && (grant_idx == IDX_W'(i));
      if (clr[i])
        pending_p0[i] = 1'b0;
      else if (req[i])
        pending_p0[i] = 1'b1;
      else if (accept_vec[i] && (CLR_ON_GRANT != 0))
        pending_p0[i] = 1'b0;
    end
  end

  // A request hitting a still-pending channel is lost unless that channel is
  // being accepted this cycle (then it re-arms instead).
  assign drop_hit   = |(req & ~clr & pending_p1 & ~accept_vec);
  assign dropped_p0 = sat_inc(dropped_p1, drop_hit);
  assign rr_ptr_p0  = accept ? wrap_inc(grant_idx) : rr_ptr_p1;

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_p1 <= '0;
      rr_ptr_p1  <= '0;
      dropped_p1 <= '0;
    end else begin
      pending_p1 <= pending_p0;
      rr_ptr_p1  <= rr_ptr_p0;
      dropped_p1 <= dropped_p0;
    end
  end

  assign pending = pending_p1;
  assign dropped = dropped_p1;

endmodule

// File: tb/tb_pending_req_arbiter.sv
// Directed bench for pending_req_arbiter: one instance in clear-on-grant mode,
// one in hold mode, each compared against hand-computed values.
module tb_pending_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;

  logic [3:0] req1, clr1;
  logic       gr1;
  logic [3:0] pend1;
  logic       valid1;
  logic [1:0] idx1;
  logic [7:0] drop1;

  logic [3:0] req0, clr0;
  logic       gr0;
  logic [3:0] pend0;
  logic       valid0;
  logic [1:0] idx0;
  logic [7:0] drop0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_req_arbiter #(.NUM_CH(4), .DROP_W(8), .CLR_ON_GRANT(1)) dut1 (
    .clk (clk), .rst (rst), .req (req1), .clr (clr1), .grant_ready (gr1),
    .pending (pend1), .grant_valid (valid1), .grant_idx (idx1), .dropped (drop1)
  );

  pending_req_arbiter #(.NUM_CH(4), .DROP_W(8), .CLR_ON_GRANT(0)) dut0 (
    .clk (clk), .rst (rst), .req (req0), .clr (clr0), .grant_ready (gr0),
    .pending (pend0), .grant_valid (valid0), .grant_idx (idx0), .dropped (drop0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req1 = '0; clr1 = '0; gr1 = 1'b0;
    req0 = '0; clr0 = '0; gr0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_pending", 32'(pend1), 32'h0);
    chk("rst_dropped", 32'(drop1), 32'h0);
    chk("rst_valid", 32'(valid1), 32'h0);
    chk("rst_idx", 32'(idx1), 32'h0);

    // clr beats req on the same channel
    req1 = 4'b0001; clr1 = 4'b0001;
    step();
    chk("prio_clr_wins", 32'(pend1), 32'h0);
    clr1 = 4'b0000;
    step();
    chk("prio_req_sets", 32'(pend1), 32'h1);
    chk("prio_valid", 32'(valid1), 32'h1);
    chk("prio_idx", 32'(idx1), 32'h0);

    // build pending=1011 (ch0 already pending -> one drop), then async reset
    req1 = 4'b1011;
    step();
    req1 = 4'b0000;
    chk("pre_rst_pending", 32'(pend1), 32'hb);
    chk("pre_rst_dropped", 32'(drop1), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pending", 32'(pend1), 32'h0);
    chk("async_rst_dropped", 32'(drop1), 32'h0);
    chk("async_rst_valid", 32'(valid1), 32'h0);
    chk("async_rst_idx", 32'(idx1), 32'h0);
    step();
    rst = 1'b0;

    // rotation over all four channels
    req1 = 4'b1111;
    step();
    req1 = 4'b0000; gr1 = 1'b1;
    chk("rot_pending", 32'(pend1), 32'hf);
    chk("rot_idx0", 32'(idx1), 32'h0);
    step();
    chk("rot_idx1", 32'(idx1), 32'h1);
    step();
    chk("rot_idx2", 32'(idx1), 32'h2);
    step();
    chk("rot_idx3", 32'(idx1), 32'h3);
    step();
    chk("rot_empty_pending", 32'(pend1), 32'h0);
    chk("rot_empty_valid", 32'(valid1), 32'h0);
    chk("rot_empty_idx", 32'(idx1), 32'h0);
    gr1 = 1'b0;

    // drive rr_ptr to 3 by accepting ch2, then check wrap
    req1 = 4'b0100;
    step();
    req1 = 4'b0000; gr1 = 1'b1;
    chk("wrap_setup_idx", 32'(idx1), 32'h2);
    step();
    gr1 = 1'b0; req1 = 4'b0011;
    step();
    req1 = 4'b0000;
    chk("wrap_idx0", 32'(idx1), 32'h0);
    step();
    chk("wrap_hold_idx", 32'(idx1), 32'h0);
    gr1 = 1'b1;
    step();
    chk("wrap_idx1", 32'(idx1), 32'h1);
    chk("wrap_pending", 32'(pend1), 32'h2);
    step();
    gr1 = 1'b0;
    chk("wrap_drain", 32'(pend1), 32'h0);

    // re-arm: accept ch2 while req[2]=1 (rr_ptr=2 now)
    req1 = 4'b0100;
    step();
    gr1 = 1'b1;
    chk("rearm_idx", 32'(idx1), 32'h2);
    step();
    gr1 = 1'b0; req1 = 4'b0000;
    chk("rearm_pending", 32'(pend1), 32'h4);
    chk("rearm_no_drop", 32'(drop1), 32'h0);

    // drops: ch1 new, then repeated
    req1 = 4'b0010;
    step();
    chk("drop_first_set", 32'(drop1), 32'h0);
    chk("stable_idx_a", 32'(idx1), 32'h1);
    step();
    chk("drop_one", 32'(drop1), 32'h1);
    chk("stable_idx_b", 32'(idx1), 32'h1);
    req1 = 4'b0110;
    step();
    chk("drop_multi_once", 32'(drop1), 32'h2);
    req1 = 4'b0010;
    for (int i = 0; i < 300; i++) step();
    chk("drop_saturate", 32'(drop1), 32'hff);
    step();
    chk("drop_stays_sat", 32'(drop1), 32'hff);
    req1 = 4'b0000; clr1 = 4'b1111;
    step();
    clr1 = 4'b0000;
    chk("clr_all", 32'(pend1), 32'h0);

    // hold mode: ch0 and ch2 granted alternately, pending held
    req0 = 4'b0101;
    step();
    req0 = 4'b0000; gr0 = 1'b1;
    chk("m0_idx_a", 32'(idx0), 32'h0);
    step();
    chk("m0_idx_b", 32'(idx0), 32'h2);
    chk("m0_pend_b", 32'(pend0), 32'h5);
    step();
    chk("m0_idx_c", 32'(idx0), 32'h0);
    step();
    chk("m0_idx_d", 32'(idx0), 32'h2);
    chk("m0_pend_d", 32'(pend0), 32'h5);
    gr0 = 1'b0; clr0 = 4'b0101;
    step();
    clr0 = 4'b0000;
    chk("m0_clr", 32'(pend0), 32'h0);
    chk("m0_valid_off", 32'(valid0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
